// File: rtl/pjon_frame_rx.sv
// pjon_frame_rx: receive-side PJON frame parser sitting behind pjdl.
// Checks ID/HEADER/LEN/HCRC and the frame CRC8, forwards only payload bytes
// downstream, and reports one status pulse per frame.
// Optional feature macro: PJON_FRAME_RX_BROADCAST_EN (accept ID 8'h00 as broadcast).
// rst_n is the codebase's historical reset net: asynchronous and active-HIGH.

module pjon_frame_rx #(
  parameter logic [7:0] DeviceId = 8'h01,
  parameter logic [7:0] MaxLen   = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       m_tuser,
  input  logic       m_tready,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [2:0] err_code_o
);

  typedef enum logic [2:0] {
    ST_ID      = 3'd0,
    ST_HDR     = 3'd1,
    ST_LEN     = 3'd2,
    ST_HCRC    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_FCRC    = 3'd5,
    ST_DISCARD = 3'd6
  } state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ID    = 3'd1;
  localparam logic [2:0] ERR_HDR   = 3'd2;
  localparam logic [2:0] ERR_LEN   = 3'd3;
  localparam logic [2:0] ERR_HCRC  = 3'd4;
  localparam logic [2:0] ERR_FCRC  = 3'd5;
  localparam logic [2:0] ERR_TLAST = 3'd6;

  // PJON CRC8: reflected polynomial 0x97, LSB first, one whole byte per call.
  function automatic logic [7:0] crc8_fold(input logic [7:0] crc_in, input logic [7:0] data_in);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = crc_in;
    b = data_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[0];
      c  = {1'b0, c[7:1]};
      if (fb) c = c ^ 8'h97;
      else    c = c;
      b  = {1'b0, b[7:1]};
    end
    return c;
  endfunction

  // Parser state
  state_e     state_q, state_d;
  logic [7:0] crc_h_q, crc_h_d;
  logic [7:0] crc_f_q, crc_f_d;
  logic [7:0] cnt_q, cnt_d;

  // One-entry payload hold register: a payload byte waits here until the
  // next byte tells us whether it is the last one of the frame.
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;

  // Output register feeding m_*
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       out_user_q, out_user_d;

  // Status
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;

  logic       accept_s;
  logic       s_tready_s;
  logic       id_ok_s;
  logic       push_s;
  logic       push_last_s;
  logic       push_user_s;
  logic [7:0] crc_h_next_s;
  logic [7:0] crc_f_next_s;

`ifdef PJON_FRAME_RX_BROADCAST_EN
  assign id_ok_s = (s_tdata == DeviceId) || (s_tdata == 8'h00);
`else
  assign id_ok_s = (s_tdata == DeviceId);
`endif

  // The hold register is only occupied in PAYLOAD/FCRC, where every accepted
  // byte pushes it out; so a push is pending exactly when it is occupied.
  // Stall only if that push cannot land in (or swap through) the output register.
  assign s_tready_s = !(hold_valid_q && out_valid_q && !m_tready);
  assign accept_s   = s_tvalid && s_tready_s;

  assign s_tready    = s_tready_s;
  assign m_tdata     = out_data_q;
  assign m_tvalid    = out_valid_q;
  assign m_tlast     = out_last_q;
  assign m_tuser     = out_user_q;
  assign frame_ok_o  = ok_q;
  assign frame_err_o = err_q;
  assign err_code_o  = err_code_q;

  // State register and datapath flops; asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_ID;
      crc_h_q      <= 8'h00;
      crc_f_q      <= 8'h00;
      cnt_q        <= 8'h00;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      crc_h_q      <= crc_h_d;
      crc_f_q      <= crc_f_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  // Next-state, CRC tracking, hold/output register moves and status pulses.
  always_comb begin
    state_d      = state_q;
    crc_h_d      = crc_h_q;
    crc_f_d      = crc_f_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    push_s       = 1'b0;
    push_last_s  = 1'b0;
    push_user_s  = 1'b0;
    crc_h_next_s = crc8_fold(crc_h_q, s_tdata);
    crc_f_next_s = crc8_fold(crc_f_q, s_tdata);

    if (accept_s) begin
      case (state_q)
        ST_ID: begin
          // Both running CRCs restart at the first byte of a frame.
          crc_h_d = crc8_fold(8'h00, s_tdata);
          crc_f_d = crc8_fold(8'h00, s_tdata);
          if (s_tlast) begin
            err_d      = 1'b1;
            err_code_d = ERR_TLAST;
            state_d    = ST_ID;
          end else if (!id_ok_s) begin
            err_d      = 1'b1;
            err_code_d = ERR_ID;
            state_d    = ST_DISCARD;
          end else begin
            state_d = ST_HDR;
          end
        end

        ST_HDR: begin
          crc_h_d = crc_h_next_s;
          crc_f_d = crc_f_next_s;
          if (s_tlast) begin
            err_d      = 1'b1;
            err_code_d = ERR_TLAST;
            state_d    = ST_ID;
          end else if (s_tdata[5]) begin
            // CRC32 frames are not supported by this parser.
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
            state_d    = ST_DISCARD;
          end else begin
            state_d = ST_LEN;
          end
        end

        ST_LEN: begin
          crc_h_d = crc_h_next_s;
          crc_f_d = crc_f_next_s;
          if (s_tlast) begin
            err_d      = 1'b1;
            err_code_d = ERR_TLAST;
            state_d    = ST_ID;
          end else if ((s_tdata < 8'd5) || (s_tdata > MaxLen)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_DISCARD;
          end else begin
            // LEN counts ID, HDR, LEN, HCRC and FCRC as well as the payload.
            cnt_d   = s_tdata - 8'd5;
            state_d = ST_HCRC;
          end
        end

        ST_HCRC: begin
          crc_f_d = crc_f_next_s;
          if (s_tlast) begin
            err_d      = 1'b1;
            err_code_d = ERR_TLAST;
            state_d    = ST_ID;
          end else if (s_tdata != crc_h_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_HCRC;
            state_d    = ST_DISCARD;
          end else if (cnt_q != 8'd0) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_FCRC;
          end
        end

        ST_PAYLOAD: begin
          push_s = hold_valid_q;
          if (s_tlast) begin
            // Truncated frame: close the downstream packet as corrupt.
            push_last_s  = 1'b1;
            push_user_s  = 1'b1;
            hold_valid_d = 1'b0;
            err_d        = 1'b1;
            err_code_d   = ERR_TLAST;
            state_d      = ST_ID;
          end else begin
            push_last_s  = 1'b0;
            push_user_s  = 1'b0;
            hold_valid_d = 1'b1;
            hold_data_d  = s_tdata;
            crc_f_d      = crc_f_next_s;
            cnt_d        = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = ST_FCRC;
            else               state_d = ST_PAYLOAD;
          end
        end

        ST_FCRC: begin
          push_s       = hold_valid_q;
          push_last_s  = 1'b1;
          push_user_s  = (s_tdata != crc_f_q);
          hold_valid_d = 1'b0;
          if (!s_tlast) begin
            // Frame continues past its own CRC: treat the tail as garbage.
            err_d      = 1'b1;
            err_code_d = ERR_TLAST;
            state_d    = ST_DISCARD;
          end else if (s_tdata != crc_f_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_FCRC;
            state_d    = ST_ID;
          end else begin
            ok_d       = 1'b1;
            err_code_d = ERR_NONE;
            state_d    = ST_ID;
          end
        end

        ST_DISCARD: begin
          if (s_tlast) state_d = ST_ID;
          else         state_d = ST_DISCARD;
        end

        default: begin
          state_d = ST_ID;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Output register: a push may coincide with a pop, giving 1 beat/cycle.
    if (push_s) begin
      out_valid_d = 1'b1;
      out_data_d  = hold_data_q;
      out_last_d  = push_last_s;
      out_user_d  = push_user_s;
    end else if (out_valid_q && m_tready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

endmodule

// File: tb/tb_pjon_frame_rx.sv
// Directed self-checking bench for pjon_frame_rx.
// Inputs are driven on the falling edge; a monitor samples outputs 3 ns
// after each falling edge and records payload beats and status pulses.

module tb_pjon_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tuser;
  logic       m_tready;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [2:0] err_code_o;

  int checks;
  int errors;

  logic [8:0] fr[$];       // {last, data} bytes still to send
  logic [9:0] beat_q[$];   // {user, last, data} beats seen on m_*
  logic [2:0] code_q[$];   // err_code_o at each frame_err_o pulse
  int         ok_n;
  int         err_n;
  bit         stall_seen;

  pjon_frame_rx #(.DeviceId(8'h01), .MaxLen(8'd64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready),
    .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  // Monitor: one sample per cycle, well before the next rising edge.
  always @(negedge clk) begin
    #3;
    if (m_tvalid && m_tready) beat_q.push_back({m_tuser, m_tlast, m_tdata});
    if (frame_ok_o) ok_n++;
    if (frame_err_o) begin
      err_n++;
      code_q.push_back(err_code_o);
    end
    if (s_tvalid && !s_tready) stall_seen = 1'b1;
  end

  // Reference CRC8 (table-free reflected form: xor byte in, then shift).
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 8'h97) : (r >> 1);
    return r;
  endfunction

  function automatic logic [9:0] beat_at(input int i);
    if (i < beat_q.size()) return beat_q[i];
    return 10'h3FF;
  endfunction

  function automatic logic [2:0] code_at(input int i);
    if (i < code_q.size()) return code_q[i];
    return 3'd7;
  endfunction

  task automatic add(input logic [7:0] d, input bit last);
    fr.push_back({last, d});
  endtask

  // Well-formed frame with n (0..2) payload bytes; corrupt flips FCRC bit 0.
  task automatic add_good(input logic [7:0] id, input logic [7:0] hdr, input int n,
                          input logic [7:0] p0, input logic [7:0] p1, input bit corrupt);
    logic [7:0] c;
    logic [7:0] len;
    len = 8'(n + 5);
    c = ref_crc(8'h00, id);
    c = ref_crc(c, hdr);
    c = ref_crc(c, len);
    add(id, 1'b0); add(hdr, 1'b0); add(len, 1'b0); add(c, 1'b0);
    c = ref_crc(c, c);
    if (n > 0) begin add(p0, 1'b0); c = ref_crc(c, p0); end
    if (n > 1) begin add(p1, 1'b0); c = ref_crc(c, p1); end
    add(corrupt ? (c ^ 8'h01) : c, 1'b1);
  endtask

  task automatic send_all();
    int n;
    for (int i = 0; i < fr.size(); i++) begin
      s_tdata  = fr[i][7:0];
      s_tlast  = fr[i][8];
      s_tvalid = 1'b1;
      n = 0;
      #1;
      while (!s_tready && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL send_timeout: byte %0d s_tready stuck at %b, required 1", i, s_tready);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    fr.delete();
  endtask

  task automatic clear_mon();
    @(negedge clk);
    beat_q.delete();
    code_q.delete();
    ok_n = 0;
    err_n = 0;
    stall_seen = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    repeat (8) @(negedge clk);
    #4;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b required 1", s_tready); end
    checks++; if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 11'h000) begin errors++; $display("FAIL reset_m_out: got %h required 000", {m_tvalid, m_tlast, m_tuser, m_tdata}); end
    checks++; if ({frame_ok_o, frame_err_o, err_code_o} !== 5'h00) begin errors++; $display("FAIL reset_status: got %h required 00", {frame_ok_o, frame_err_o, err_code_o}); end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    clear_mon();
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h06, 1'b0);
    add(8'h54, 1'b0); add(8'h41, 1'b0); add(8'h5A, 1'b1);
    send_all();
    drain();
    checks++; if (beat_q.size() !== 1) begin errors++; $display("FAIL good_nbeats: got %0d required 1", beat_q.size()); end
    checks++; if (beat_at(0) !== 10'h141) begin errors++; $display("FAIL good_beat: got %h required 141", beat_at(0)); end
    checks++; if (ok_n !== 1 || err_n !== 0) begin errors++; $display("FAIL good_pulses: got ok=%0d err=%0d required ok=1 err=0", ok_n, err_n); end
    checks++; if (err_code_o !== 3'd0) begin errors++; $display("FAIL good_code: got %0d required 0", err_code_o); end
  endtask

  task automatic test_bad_fcrc();
    clear_mon();
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h06, 1'b0);
    add(8'h54, 1'b0); add(8'h41, 1'b0); add(8'h5B, 1'b1);
    send_all();
    drain();
    checks++; if (beat_at(0) !== 10'h341 || beat_q.size() !== 1) begin errors++; $display("FAIL badcrc_beat: got %h (n=%0d) required 341 (n=1)", beat_at(0), beat_q.size()); end
    checks++; if (ok_n !== 0 || err_n !== 1) begin errors++; $display("FAIL badcrc_pulses: got ok=%0d err=%0d required ok=0 err=1", ok_n, err_n); end
    checks++; if (err_code_o !== 3'd5) begin errors++; $display("FAIL badcrc_code: got %0d required 5", err_code_o); end
  endtask

  task automatic test_id_mismatch();
    clear_mon();
    add_good(8'h02, 8'h00, 1, 8'h77, 8'h00, 1'b0);
    add_good(8'h01, 8'h00, 1, 8'h41, 8'h00, 1'b0);
    send_all();
    drain();
    checks++; if (code_at(0) !== 3'd1 || err_n !== 1) begin errors++; $display("FAIL idmis_code: got %0d (n=%0d) required 1 (n=1)", code_at(0), err_n); end
    checks++; if (ok_n !== 1) begin errors++; $display("FAIL idmis_next_ok: got %0d required 1", ok_n); end
    checks++; if (beat_at(0) !== 10'h141 || beat_q.size() !== 1) begin errors++; $display("FAIL idmis_beats: got %h (n=%0d) required 141 (n=1)", beat_at(0), beat_q.size()); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    add_good(8'h01, 8'h00, 2, 8'hA5, 8'h3C, 1'b0);
    fork
      send_all();
      begin
        m_tready = 1'b0;
        repeat (10) @(negedge clk);
        m_tready = 1'b1;
      end
    join
    drain();
    checks++; if (stall_seen !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b required 1", stall_seen); end
    checks++; if (beat_q.size() !== 2) begin errors++; $display("FAIL bp_nbeats: got %0d required 2", beat_q.size()); end
    checks++; if (beat_at(0) !== 10'h0A5) begin errors++; $display("FAIL bp_beat0: got %h required 0A5", beat_at(0)); end
    checks++; if (beat_at(1) !== 10'h13C) begin errors++; $display("FAIL bp_beat1: got %h required 13C", beat_at(1)); end
    checks++; if (ok_n !== 1 || err_n !== 0) begin errors++; $display("FAIL bp_pulses: got ok=%0d err=%0d required ok=1 err=0", ok_n, err_n); end
  endtask

  task automatic test_premature_tlast();
    clear_mon();
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h06, 1'b0); add(8'h54, 1'b1);
    add_good(8'h01, 8'h00, 1, 8'h41, 8'h00, 1'b0);
    send_all();
    drain();
    checks++; if (code_at(0) !== 3'd6 || err_n !== 1) begin errors++; $display("FAIL early_code: got %0d (n=%0d) required 6 (n=1)", code_at(0), err_n); end
    checks++; if (ok_n !== 1 || beat_q.size() !== 1) begin errors++; $display("FAIL early_next: got ok=%0d beats=%0d required ok=1 beats=1", ok_n, beat_q.size()); end
  endtask

  task automatic test_field_errors();
    clear_mon();
    add_good(8'h01, 8'h20, 1, 8'h41, 8'h00, 1'b0);                                  // CRC32 bit
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h04, 1'b0); add(8'h00, 1'b0); add(8'h00, 1'b1); // LEN 4
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h41, 1'b0); add(8'h00, 1'b1);                  // LEN 65
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h06, 1'b0); add(8'h55, 1'b0); add(8'h41, 1'b0); add(8'h5A, 1'b1); // HCRC
    send_all();
    drain();
    checks++; if (err_n !== 4 || ok_n !== 0) begin errors++; $display("FAIL field_pulses: got err=%0d ok=%0d required err=4 ok=0", err_n, ok_n); end
    checks++; if ({code_at(0), code_at(1), code_at(2), code_at(3)} !== {3'd2, 3'd3, 3'd3, 3'd4}) begin
      errors++; $display("FAIL field_codes: got %0d %0d %0d %0d required 2 3 3 4", code_at(0), code_at(1), code_at(2), code_at(3));
    end
    checks++; if (beat_q.size() !== 0) begin errors++; $display("FAIL field_beats: got %0d required 0", beat_q.size()); end
  endtask

  task automatic test_len5();
    clear_mon();
    add_good(8'h01, 8'h00, 0, 8'h00, 8'h00, 1'b0);
    send_all();
    drain();
    checks++; if (ok_n !== 1 || err_n !== 0 || beat_q.size() !== 0) begin errors++; $display("FAIL len5: got ok=%0d err=%0d beats=%0d required 1 0 0", ok_n, err_n, beat_q.size()); end
  endtask

  task automatic test_fcrc_no_tlast();
    clear_mon();
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h06, 1'b0); add(8'h54, 1'b0);
    add(8'h41, 1'b0); add(8'h5A, 1'b0); add(8'hEE, 1'b1);
    send_all();
    drain();
    checks++; if (beat_at(0) !== 10'h141 || beat_q.size() !== 1) begin errors++; $display("FAIL late_beat: got %h (n=%0d) required 141 (n=1)", beat_at(0), beat_q.size()); end
    checks++; if (err_n !== 1 || ok_n !== 0 || code_at(0) !== 3'd6) begin errors++; $display("FAIL late_status: got err=%0d ok=%0d code=%0d required 1 0 6", err_n, ok_n, code_at(0)); end
  endtask

  task automatic test_payload_tlast();
    logic [7:0] h;
    clear_mon();
    h = ref_crc(ref_crc(ref_crc(8'h00, 8'h01), 8'h00), 8'h07);
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h07, 1'b0); add(h, 1'b0);
    add(8'hA5, 1'b0); add(8'h3C, 1'b1);
    send_all();
    drain();
    checks++; if (beat_at(0) !== 10'h3A5 || beat_q.size() !== 1) begin errors++; $display("FAIL trunc_beat: got %h (n=%0d) required 3A5 (n=1)", beat_at(0), beat_q.size()); end
    checks++; if (err_n !== 1 || code_at(0) !== 3'd6) begin errors++; $display("FAIL trunc_code: got %0d (n=%0d) required 6 (n=1)", code_at(0), err_n); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] h;
    clear_mon();
    h = ref_crc(ref_crc(ref_crc(8'h00, 8'h01), 8'h00), 8'h07);
    m_tready = 1'b0;
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h07, 1'b0); add(h, 1'b0);
    add(8'hA5, 1'b0); add(8'h3C, 1'b0);
    send_all();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL rstmid_out: got m_tvalid=%b s_tready=%b required 0 1", m_tvalid, s_tready); end
    add_good(8'h01, 8'h00, 1, 8'h41, 8'h00, 1'b0);
    @(negedge clk);
    send_all();
    drain();
    checks++; if (err_n !== 0 || ok_n !== 1 || beat_at(0) !== 10'h141 || beat_q.size() !== 1) begin
      errors++; $display("FAIL rstmid_after: got err=%0d ok=%0d beat=%h n=%0d required 0 1 141 1", err_n, ok_n, beat_at(0), beat_q.size());
    end
  endtask

  task automatic test_broadcast();
    clear_mon();
    add_good(8'h00, 8'h00, 1, 8'h41, 8'h00, 1'b0);
    send_all();
    drain();
`ifdef PJON_FRAME_RX_BROADCAST_EN
    checks++; if (ok_n !== 1 || err_n !== 0 || beat_at(0) !== 10'h141) begin errors++; $display("FAIL bcast_on: got ok=%0d err=%0d beat=%h required 1 0 141", ok_n, err_n, beat_at(0)); end
`else
    checks++; if (ok_n !== 0 || err_n !== 1 || code_at(0) !== 3'd1 || beat_q.size() !== 0) begin
      errors++; $display("FAIL bcast_off: got ok=%0d err=%0d code=%0d beats=%0d required 0 1 1 0", ok_n, err_n, code_at(0), beat_q.size());
    end
`endif
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ok_n       = 0;
    err_n      = 0;
    stall_seen = 1'b0;
    rst_n      = 1'b1;
    s_tdata    = 8'h00;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    m_tready   = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_fcrc();
    test_id_mismatch();
    test_backpressure();
    test_premature_tlast();
    test_field_errors();
    test_len5();
    test_fcrc_no_tlast();
    test_payload_tlast();
    test_reset_mid_frame();
    test_broadcast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
